// File: rtl/io_port_pkg.sv
// Shared constants and address decode for the io_port_bank peripheral.
// Each channel occupies a 16-byte window holding four word registers.
package io_port_pkg;

    localparam logic [3:0]  OFF_OUT    = 4'h0;
    localparam logic [3:0]  OFF_IN     = 4'h4;
    localparam logic [3:0]  OFF_IRQ_EN = 4'h8;
    localparam logic [3:0]  OFF_FLAG   = 4'hC;
    localparam int unsigned CH_STRIDE  = 32'h10;

    typedef enum logic [1:0] {
        REG_OUT    = OFF_OUT[3:2],
        REG_IN     = OFF_IN[3:2],
        REG_IRQ_EN = OFF_IRQ_EN[3:2],
        REG_FLAG   = OFF_FLAG[3:2]
    } reg_sel_e;

    typedef struct packed {
        logic [27:0] ch;
        reg_sel_e    sel;
    } addr_dec_t;

    // Byte address -> channel index and word register; bits [1:0] are dropped.
    function automatic addr_dec_t decode_addr(input logic [31:0] a);
        addr_dec_t d;
        d.ch  = 28'(a / CH_STRIDE);
        d.sel = reg_sel_e'(a[3:2]);
        return d;
    endfunction

endpackage

// File: rtl/io_sync_edge.sv
// Per-channel input conditioning: multi-stage synchroniser, previous-value
// register and rising-edge pulse (rise = sync & ~prev).
module io_sync_edge #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_sync,
    output logic [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] r_chain [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;

    // NOTE: non-blocking assignments let every stage sample the old value of
    // its predecessor, which is what makes this a shift chain and not a wire.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_chain[s] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_chain[0] <= i_din;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_chain[s] <= r_chain[s-1];
            end
            r_prev <= r_chain[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_chain[SYNC_STAGES-1];
    assign o_rise = o_sync & ~r_prev;

endmodule

// File: rtl/io_port_bank.sv
// Memory-mapped parallel I/O bank: per-channel OUT / IN / IRQ_EN / FLAG
// registers, sticky write-1-to-clear edge flags and one level interrupt.
module io_port_bank
    import io_port_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int CHANNELS    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 8
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [31:0]               wdata,
    input  logic                      we,
    output logic [31:0]               rdata,
    input  logic [CHANNELS*WIDTH-1:0] DIN,
    output logic [CHANNELS*WIDTH-1:0] DOUT,
    output logic                      irq
);

    addr_dec_t           w_dec;
    logic [WIDTH-1:0]    w_wdata;
    logic [WIDTH-1:0]    w_sync  [CHANNELS];
    logic [WIDTH-1:0]    w_rise  [CHANNELS];
    logic [WIDTH-1:0]    w_clr   [CHANNELS];
    logic [CHANNELS-1:0] w_wr;
    logic [CHANNELS-1:0] w_ch_irq;
    logic                w_unused;

    logic [WIDTH-1:0] r_out    [CHANNELS];
    logic [WIDTH-1:0] r_irq_en [CHANNELS];
    logic [WIDTH-1:0] r_flag   [CHANNELS];

    assign w_dec    = decode_addr(32'(addr));
    assign w_wdata  = wdata[WIDTH-1:0];
    assign w_unused = ^{wdata, addr[1:0]};

    // Channel indices past CHANNELS match no w_wr bit, so those writes vanish.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        io_sync_edge #(
            .WIDTH       (WIDTH),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync_edge (
            .CLK     (CLK),
            .RESET_N (RESET_N),
            .i_din   (DIN[c*WIDTH +: WIDTH]),
            .o_sync  (w_sync[c]),
            .o_rise  (w_rise[c])
        );

        assign w_wr[c]     = we && (w_dec.ch == 28'(c));
        assign w_clr[c]    = (w_wr[c] && w_dec.sel == REG_FLAG) ? w_wdata : '0;
        assign DOUT[c*WIDTH +: WIDTH] = r_out[c];
        assign w_ch_irq[c] = |(r_flag[c] & r_irq_en[c]);
    end

    assign irq = |w_ch_irq;

    // NOTE: these register arrays are small flop banks, not RAM, so every
    // entry is reset; that is what drives DOUT and irq low asynchronously.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_out[c]    <= '0;
                r_irq_en[c] <= '0;
                r_flag[c]   <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_wr[c] && w_dec.sel == REG_OUT) begin
                    r_out[c] <= w_wdata;
                end
                if (w_wr[c] && w_dec.sel == REG_IRQ_EN) begin
                    r_irq_en[c] <= w_wdata;
                end
                // Set beats clear: an edge arriving with its own clear survives.
                r_flag[c] <= (r_flag[c] & ~w_clr[c]) | w_rise[c];
            end
        end
    end

    // NOTE: rdata gets its default before any branch so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        rdata = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_dec.ch == 28'(c)) begin
                case (w_dec.sel)
                    REG_OUT:    rdata = 32'(r_out[c]);
                    REG_IN:     rdata = 32'(w_sync[c]);
                    REG_IRQ_EN: rdata = 32'(r_irq_en[c]);
                    REG_FLAG:   rdata = 32'(r_flag[c]);
                    default:    rdata = '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_io_port_bank.sv
// Directed and randomized bench for io_port_bank, checked against a
// register-map model that treats the synchroniser as a DIN history queue.
module tb_io_port_bank;

    localparam int WIDTH       = 16;
    localparam int CHANNELS    = 2;
    localparam int SYNC_STAGES = 2;
    localparam int ADDR_W      = 8;
    localparam int DW          = CHANNELS * WIDTH;

    logic              CLK = 1'b0;
    logic              RESET_N = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [31:0]       wdata = '0;
    logic              we = 1'b0;
    logic [31:0]       rdata;
    logic [DW-1:0]     DIN = '0;
    logic [DW-1:0]     DOUT;
    logic              irq;

    int checks = 0;
    int errors = 0;

    io_port_bank #(
        .WIDTH       (WIDTH),
        .CHANNELS    (CHANNELS),
        .SYNC_STAGES (SYNC_STAGES),
        .ADDR_W      (ADDR_W)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .addr    (addr),
        .wdata   (wdata),
        .we      (we),
        .rdata   (rdata),
        .DIN     (DIN),
        .DOUT    (DOUT),
        .irq     (irq)
    );

    always #5 CLK = ~CLK;

    // Reference model: register contents plus DIN as sampled at each edge, newest first.
    logic [WIDTH-1:0] m_out  [CHANNELS];
    logic [WIDTH-1:0] m_en   [CHANNELS];
    logic [WIDTH-1:0] m_flag [CHANNELS];
    logic [DW-1:0]    m_hist [$];

    function automatic void m_reset();
        for (int c = 0; c < CHANNELS; c++) begin
            m_out[c]  = '0;
            m_en[c]   = '0;
            m_flag[c] = '0;
        end
        m_hist.delete();
    endfunction

    function automatic logic [DW-1:0] m_tap(input int k);
        return (m_hist.size() > k) ? m_hist[k] : '0;
    endfunction

    function automatic logic [31:0] m_read(input logic [ADDR_W-1:0] a);
        int ch;
        int off;
        logic [DW-1:0] s;
        ch  = int'(a) / 16;
        off = (int'(a) % 16) / 4;
        s   = m_tap(SYNC_STAGES - 1);
        if (ch >= CHANNELS) return 32'h0;
        case (off)
            0:       return 32'(m_out[ch]);
            1:       return 32'(s[ch*WIDTH +: WIDTH]);
            2:       return 32'(m_en[ch]);
            default: return 32'(m_flag[ch]);
        endcase
    endfunction

    function automatic void m_edge(input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                                   input logic w, input logic [DW-1:0] din);
        int ch;
        int off;
        logic [DW-1:0]    rise;
        logic [WIDTH-1:0] clr;
        ch   = int'(a) / 16;
        off  = (int'(a) % 16) / 4;
        rise = m_tap(SYNC_STAGES - 1) & ~m_tap(SYNC_STAGES);
        for (int c = 0; c < CHANNELS; c++) begin
            clr = '0;
            if (w && ch == c) begin
                if (off == 0) m_out[c] = wd[WIDTH-1:0];
                if (off == 2) m_en[c]  = wd[WIDTH-1:0];
                if (off == 3) clr      = wd[WIDTH-1:0];
            end
            m_flag[c] = (m_flag[c] & ~clr) | rise[c*WIDTH +: WIDTH];
        end
        m_hist.push_front(din);
        if (m_hist.size() > SYNC_STAGES + 1) void'(m_hist.pop_back());
    endfunction

    function automatic logic [DW-1:0] m_dout();
        logic [DW-1:0] d;
        for (int c = 0; c < CHANNELS; c++) d[c*WIDTH +: WIDTH] = m_out[c];
        return d;
    endfunction

    function automatic logic m_irq();
        logic r;
        r = 1'b0;
        for (int c = 0; c < CHANNELS; c++) r |= |(m_flag[c] & m_en[c]);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge: drive, check the combinational read,
    // take one rising edge, then check the registered outputs.
    task automatic step(input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                        input logic w, input logic [DW-1:0] din);
        addr  = a;
        wdata = wd;
        we    = w;
        DIN   = din;
        #1;
        check("rdata", rdata, m_read(a));
        @(posedge CLK);
        m_edge(a, wd, w, din);
        @(negedge CLK);
        we = 1'b0;
        check("dout", DOUT, m_dout());
        check("irq", 32'(irq), 32'(m_irq()));
    endtask

    task automatic peek(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
        addr = a;
        we   = 1'b0;
        #1;
        check(tag, rdata, exp);
    endtask

    initial begin
        logic [DW-1:0] din;
        m_reset();

        // Reset state
        @(negedge CLK);
        @(negedge CLK);
        check("reset_dout", DOUT, 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        peek("reset_flag", 8'h0C, 32'h0);
        RESET_N = 1'b1;

        // Output write and readback
        step(8'h00, 32'h1234_BEEF, 1'b1, '0);
        step(8'h10, 32'h0000_00FF, 1'b1, '0);
        check("dout_write", DOUT, 32'h00FF_BEEF);
        peek("out0_readback", 8'h00, 32'h0000_BEEF);

        // Input synchroniser and edge flag on bit 3
        step(8'h08, 32'h0000_0008, 1'b1, '0);
        step(8'h04, 32'h0, 1'b0, 32'h0000_0008);
        peek("in_not_yet", 8'h04, 32'h0);
        step(8'h04, 32'h0, 1'b0, 32'h0000_0008);
        peek("in_after_1", 8'h04, 32'h0000_0008);
        check("irq_before_flag", 32'(irq), 32'h0);
        step(8'h0C, 32'h0, 1'b0, 32'h0000_0008);
        peek("flag_after_2", 8'h0C, 32'h0000_0008);
        check("irq_after_2", 32'(irq), 32'h1);
        for (int i = 0; i < 3; i++) step(8'h0C, 32'h0, 1'b0, '0);
        peek("flag_sticky", 8'h0C, 32'h0000_0008);

        // Clear racing a new edge on bit 0
        step(8'h08, 32'h0000_0009, 1'b1, '0);
        for (int i = 0; i < 3; i++) step(8'h00, 32'h0, 1'b0, 32'h1);
        peek("flag_0009", 8'h0C, 32'h0000_0009);
        for (int i = 0; i < 2; i++) step(8'h00, 32'h0, 1'b0, '0);
        for (int i = 0; i < 2; i++) step(8'h00, 32'h0, 1'b0, 32'h1);
        peek("flag_pre_clear", 8'h0C, 32'h0000_0009);
        step(8'h0C, 32'h0000_0009, 1'b1, 32'h1);
        peek("flag_set_wins", 8'h0C, 32'h0000_0001);
        check("irq_held", 32'(irq), 32'h1);

        // Masking on channel 1
        step(8'h0C, 32'h0000_FFFF, 1'b1, '0);
        check("irq_cleared", 32'(irq), 32'h0);
        for (int i = 0; i < 3; i++) step(8'h1C, 32'h0, 1'b0, 32'h0100_0000);
        peek("flag1_set", 8'h1C, 32'h0000_0100);
        check("irq_masked", 32'(irq), 32'h0);
        step(8'h18, 32'h0000_0100, 1'b1, 32'h0100_0000);
        check("irq_unmasked", 32'(irq), 32'h1);

        // Out-of-range and read-only accesses
        peek("oor_read", 8'h20, 32'h0);
        step(8'h24, 32'h0000_FFFF, 1'b1, 32'h0100_0000);
        step(8'h2C, 32'h0000_FFFF, 1'b1, 32'h0100_0000);
        check("oor_dout", DOUT, 32'h00FF_BEEF);
        peek("oor_en0", 8'h08, 32'h0000_0009);
        peek("oor_en1", 8'h18, 32'h0000_0100);
        peek("oor_flag1", 8'h1C, 32'h0000_0100);
        step(8'h04, 32'h0000_FFFF, 1'b1, 32'h0100_0000);
        peek("in_ro", 8'h04, 32'h0);
        peek("in1", 8'h14, 32'h0000_0100);

        // Asynchronous reset mid-run with OUT=0xA5A5 and FLAG=0x0003
        step(8'h0C, 32'h0000_FFFF, 1'b1, '0);
        step(8'h1C, 32'h0000_FFFF, 1'b1, '0);
        step(8'h08, 32'h0000_0003, 1'b1, '0);
        step(8'h00, 32'h0, 1'b0, 32'h3);
        step(8'h00, 32'h0, 1'b0, 32'h3);
        step(8'h00, 32'h0000_A5A5, 1'b1, 32'h3);
        peek("pre_reset_flag", 8'h0C, 32'h0000_0003);
        peek("pre_reset_out", 8'h00, 32'h0000_A5A5);
        check("pre_reset_irq", 32'(irq), 32'h1);
        addr = 8'h0C;
        #1;
        RESET_N = 1'b0;
        #1;
        check("async_dout", DOUT, 32'h0);
        check("async_irq", 32'(irq), 32'h0);
        check("async_flag", rdata, 32'h0);
        m_reset();
        @(negedge CLK);
        RESET_N = 1'b1;

        // Randomized traffic against the model
        din = '0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) din = DW'($urandom);
            step(ADDR_W'($urandom_range(0, 63)), $urandom, 1'($urandom_range(0, 1)), din);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_port_bank.md
# io_port_bank

Memory-mapped parallel I/O peripheral for the RISC-V core's data bus. It drives the board outputs (DOUT) and samples the board inputs (DIN) on a configurable number of channels, each with a configurable width. Every input bit passes through a synchroniser and a rising-edge detector that feeds sticky, write-1-to-clear flags and one level interrupt. It replaces the fixed single 16-bit DIN/DOUT pair used by the current system bench and top level.

## Interface

Parameters:
- WIDTH, 16, bits per channel (1..32)
- CHANNELS, 2, number of independent I/O channels (1..8)
- SYNC_STAGES, 2, input synchroniser depth (>=2)
- ADDR_W, 8, byte-address bits decoded by the block

Ports:
- CLK  in  1  system clock; all state updates on its rising edge
- RESET_N  in  1  asynchronous, active-low reset
- addr  in  ADDR_W  byte address from the core; bits [1:0] are ignored
- wdata  in  32  write data (ddata_w)
- we  in  1  write strobe, from the core's d_rw qualified by the peripheral select
- rdata  out  32  read data (to ddata_r), combinational from addr
- DIN  in  CHANNELS*WIDTH  asynchronous board inputs; channel c occupies bits [c*WIDTH +: WIDTH]
- DOUT  out  CHANNELS*WIDTH  registered board outputs, same packing as DIN
- irq  out  1  level interrupt: OR over all channels of (flag & irq_en)

## Operation

Register map: channel c has base address c*0x10. Offsets within a channel:
- 0x0 OUT: read/write; drives DOUT for the channel
- 0x4 IN: read-only; synchronised DIN
- 0x8 IRQ_EN: read/write; per-bit rising-edge interrupt enable
- 0xC FLAG: read; a write clears every bit written as 1

Register width and read rules:
- Registers are WIDTH bits wide. Write data uses wdata[WIDTH-1:0]; the upper bits are ignored.
- Reads zero-extend to 32 bits.

Input path, per bit:
- DIN passes through a SYNC_STAGES flip-flop chain to give sync.
- A further register holds prev.
- rise = sync & ~prev.
- FLAG bit update: next = (FLAG & ~clr) | rise.
- An edge and a clear on the same bit in the same cycle leave the bit set, because the set wins.
- Flags latch regardless of IRQ_EN. IRQ_EN gates only irq.

Decode rules:
- Any address with channel index >= CHANNELS reads 0, and writes to it are ignored.
- Writes to IN are ignored.
- we=0 causes no state change.

Reset:
- All registers (OUT, IRQ_EN, FLAG, the synchroniser chain and prev) reset to 0.
- Therefore DOUT=0 and irq=0 during reset and on release.
- prev resets to 0, so an input held high through reset produces exactly one FLAG set once it has propagated after release. This is intended.
- Asserting reset mid-operation clears all state immediately, independent of CLK.

## Timing

- Write: with we=1 at rising edge N, the register updates at edge N, and DOUT or irq reflects it after edge N. Write latency is 1 cycle.
- Read: rdata is combinational from addr and the current register contents, so it is valid in the same cycle as the single-cycle core's load.
- Input latency: a DIN change that meets setup before edge N appears in IN after edge N+SYNC_STAGES-1. The matching FLAG bit sets at edge N+SYNC_STAGES. irq rises in the same cycle as the FLAG bit.
- A read of FLAG in the same cycle as a write-1-to-clear returns the pre-clear value.

## Structure

- Package io_port_pkg holds:
  - offset constants OFF_OUT, OFF_IN, OFF_IRQ_EN, OFF_FLAG
  - CH_STRIDE = 0x10
  - a function that decodes channel and offset from addr
- Sub-module io_sync_edge (parameter WIDTH, SYNC_STAGES) contains the synchroniser chain, the prev register and the rise output. It is instantiated once per channel in a generate loop.
- The top level contains the register file, the decode, the read multiplexer and the irq reduction.
- The system bench interface is extended with these ports, parametrised by WIDTH and CHANNELS.

## Test plan

1. Reset behaviour: assert RESET_N=0 mid-run with OUT=0xA5A5 and FLAG=0x0003. Require DOUT=0, irq=0 and FLAG=0 immediately, without waiting for a CLK edge.
2. Output write: with CHANNELS=2 and WIDTH=16, write 0x1234_BEEF to 0x00 and 0x0000_00FF to 0x10. Require DOUT=0x00FF_BEEF and a readback of 0x0000BEEF from 0x00.
3. Input sync and edge: drive DIN bit 3 from 0 to 1 with IRQ_EN[0]=0x0008. Require IN[0]=0x0008 after 1 cycle, FLAG[0]=0x0008 and irq=1 after 2 cycles. DIN falling back to 0 leaves FLAG unchanged.
4. Write-1-to-clear with a simultaneous edge: FLAG=0x0009, then write 0x0009 to 0x0C in the same cycle a new rise arrives on bit 0. Require FLAG=0x0001 and irq to stay asserted.
5. Masking: FLAG[1]=0x0100 with IRQ_EN[1]=0 gives irq=0. Writing IRQ_EN[1]=0x0100 gives irq=1 on the next cycle.
6. Out-of-range access: read 0x20 gives 0. Write 0xFFFF to 0x24 leaves DOUT, IRQ_EN and FLAG unchanged. Write to IN 0x04 has no effect.
